sc_instr_loader: RTL and testbench
==================================

SC_INSTR_LOADER -- requirements
Module: sc_instr_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, giving instruction-memory word-address width (depth 2^ADDR_W).
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  in  1  reset; synchronous, active-low.
REQ-004 SHALL have port start  in  1  one-cycle pulse; begin or restart a load session at base.
REQ-005 SHALL have port base  in  ADDR_W  first word address, sampled on start.
REQ-006 SHALL have port finish  in  1  one-cycle pulse; end session early.
REQ-007 SHALL have port req_valid  in  1  encode request present.
REQ-008 SHALL have port req_ready  out  1  request accepted when req_valid & req_ready.
REQ-009 SHALL have port req_opsel  in  5  instruction select: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 jr, 9 addi, 10 andi, 11 ori, 12 xori, 13 lw, 14 sw, 15 beq, 16 bne, 17 lui, 18 j, 19 jal; 20-31 illegal.
REQ-010 SHALL have ports req_rs, req_rt, req_rd, req_sa  in  5 each; req_imm  in  16; req_target  in  26  operand fields.
REQ-011 SHALL have port im_we  out  1  instruction-memory write strobe.
REQ-012 SHALL have port im_addr  out  ADDR_W  word write address.
REQ-013 SHALL have port im_wdata  out  32  encoded MIPS instruction word.
REQ-014 SHALL have ports busy  out  1 (session active), done  out  1 (session ended, held), err_illegal  out  1 (one-cycle pulse), count  out  ADDR_W+1 (words written this session).

Function
REQ-015 SHALL implement states IDLE, LOAD, DONE; IDLE->LOAD on start; LOAD->DONE on finish or when count reaches 2^ADDR_W; DONE->LOAD on start; LOAD->LOAD restart on start.
REQ-016 SHALL drive req_ready = (state==LOAD) & ~start & ~finish & (count < 2^ADDR_W).
REQ-017 SHALL, on an accepted legal request in cycle N, assert im_we for exactly one cycle N+1 with im_addr = current write pointer and im_wdata = encoded word; write pointer and count increment at end of cycle N.
REQ-018 SHALL wrap the write pointer modulo 2^ADDR_W (base near top wraps to 0); count does not wrap.
REQ-019 SHALL, on an accepted illegal opsel, write nothing, leave pointer and count unchanged, and pulse err_illegal in cycle N+1.
REQ-020 SHALL encode R-type as {6'b0, rs, rt, rd, sa, funct} with funct add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000.
REQ-021 SHALL force rs=0 for sll/srl/sra, sa=0 for add/sub/and/or/xor, and rt=rd=sa=0 for jr.
REQ-022 SHALL encode I-type as {op, rs, rt, imm} with op addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111 (rs forced 0 for lui).
REQ-023 SHALL encode J-type as {op, target} with op j 000010, jal 000011.
REQ-024 SHALL, on start, load pointer from base and clear count, done, err_illegal; a write already registered from cycle N still completes in N+1.
REQ-025 SHALL hold busy=1 in LOAD only, done=1 in DONE only.

Reset
REQ-026 SHALL, while resetn=0 at a clock edge, enter IDLE with im_we=0, im_addr=0, im_wdata=0, count=0, busy=0, done=0, err_illegal=0, req_ready=0; a pending write is discarded.

Structure
REQ-027 SHALL place opsel codes, opcode and funct constants in shared package sc_isa_pkg, reused by the control-unit decoder.
REQ-028 SHALL factor field packing into combinational sub-module sc_instr_pack (opsel+fields -> word, illegal flag); sequencing stays in sc_instr_loader.

Verification
REQ-029 SHALL cover: start base=0; add rs=1 rt=2 rd=3 -> im_we next cycle, im_addr=0, im_wdata=0x00221820.
REQ-030 SHALL cover: sll rt=1 rd=2 sa=4 rs=7 -> 0x00011100; addi rt=1 imm=5 -> 0x20010005; lw rs=1 rt=2 imm=4 -> 0x8C220004; j target=0x40 -> 0x08000040.
REQ-031 SHALL cover: ADDR_W=6, base=62, 64 legal requests -> addresses 62,63,0..61, count=64, done=1, req_ready=0.
REQ-032 SHALL cover: opsel=25 accepted -> no im_we, err_illegal one cycle, next legal word lands at unchanged address.
REQ-033 SHALL cover: start coincident with req_valid in LOAD -> request not accepted, pointer=base, count=0.
REQ-034 SHALL cover: resetn low mid-session after acceptance -> no im_we next cycle, all outputs at reset values.

Source files
------------

// File: rtl/sc_isa_pkg.sv
// Shared MIPS-subset ISA constants: loader opsel codes, major opcodes and R-type funct codes.
// Latency: n/a (constants and types only).
// Backpressure: n/a. Reused by the instruction packer and the control-unit decoder.
package sc_isa_pkg;

  // Loader instruction-select codes; 20..31 are illegal.
  localparam logic [4:0] SEL_ADD  = 5'd0;
  localparam logic [4:0] SEL_SUB  = 5'd1;
  localparam logic [4:0] SEL_AND  = 5'd2;
  localparam logic [4:0] SEL_OR   = 5'd3;
  localparam logic [4:0] SEL_XOR  = 5'd4;
  localparam logic [4:0] SEL_SLL  = 5'd5;
  localparam logic [4:0] SEL_SRL  = 5'd6;
  localparam logic [4:0] SEL_SRA  = 5'd7;
  localparam logic [4:0] SEL_JR   = 5'd8;
  localparam logic [4:0] SEL_ADDI = 5'd9;
  localparam logic [4:0] SEL_ANDI = 5'd10;
  localparam logic [4:0] SEL_ORI  = 5'd11;
  localparam logic [4:0] SEL_XORI = 5'd12;
  localparam logic [4:0] SEL_LW   = 5'd13;
  localparam logic [4:0] SEL_SW   = 5'd14;
  localparam logic [4:0] SEL_BEQ  = 5'd15;
  localparam logic [4:0] SEL_BNE  = 5'd16;
  localparam logic [4:0] SEL_LUI  = 5'd17;
  localparam logic [4:0] SEL_J    = 5'd18;
  localparam logic [4:0] SEL_JAL  = 5'd19;

  // Major opcodes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type funct codes.
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // Loader session states.
  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/sc_instr_pack.sv
// Packs an opsel plus operand fields into one 32-bit MIPS word and flags illegal selects.
// Latency: purely combinational. Backpressure: none.
// Ports: opsel/rs/rt/rd/sa/imm/target in; word (encoded instruction), illegal (opsel 20..31) out.
module sc_instr_pack
  import sc_isa_pkg::*;
(
  input  logic [4:0]  opsel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  sa,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Unused register/shift fields are forced to zero so the word is canonical.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (opsel)
      SEL_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      SEL_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      SEL_AND:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      SEL_OR:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      SEL_XOR:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_XOR};
      SEL_SLL:  word = {OP_RTYPE, 5'd0, rt, rd, sa, FN_SLL};
      SEL_SRL:  word = {OP_RTYPE, 5'd0, rt, rd, sa, FN_SRL};
      SEL_SRA:  word = {OP_RTYPE, 5'd0, rt, rd, sa, FN_SRA};
      SEL_JR:   word = {OP_RTYPE, rs, 15'd0, FN_JR};
      SEL_ADDI: word = {OP_ADDI, rs, rt, imm};
      SEL_ANDI: word = {OP_ANDI, rs, rt, imm};
      SEL_ORI:  word = {OP_ORI, rs, rt, imm};
      SEL_XORI: word = {OP_XORI, rs, rt, imm};
      SEL_LW:   word = {OP_LW, rs, rt, imm};
      SEL_SW:   word = {OP_SW, rs, rt, imm};
      SEL_BEQ:  word = {OP_BEQ, rs, rt, imm};
      SEL_BNE:  word = {OP_BNE, rs, rt, imm};
      SEL_LUI:  word = {OP_LUI, 5'd0, rt, imm};
      SEL_J:    word = {OP_J, target};
      SEL_JAL:  word = {OP_JAL, target};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sc_instr_loader.sv
// Sequences encode requests into consecutive instruction-memory writes for one load session.
// Latency: accepted request in cycle N -> im_we/err_illegal in cycle N+1. Backpressure: req_ready low outside LOAD, on start/finish, or when full.
// Ports: clock/resetn (sync, active-low); start/base/finish session control; req_* handshake+fields; im_we/im_addr/im_wdata write port; busy/done/err_illegal/count status.
module sc_instr_loader
  import sc_isa_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_opsel,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_sa,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  ld_state_t         state, next_state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       pack_word;
  logic              pack_illegal;
  logic              accept;

  sc_instr_pack u_pack (
    .opsel   (req_opsel),
    .rs      (req_rs),
    .rt      (req_rt),
    .rd      (req_rd),
    .sa      (req_sa),
    .imm     (req_imm),
    .target  (req_target),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // start/finish take the cycle, so no request is accepted alongside them.
  assign req_ready = (state == LD_LOAD) & ~start & ~finish & (count < DEPTH);
  assign accept    = req_valid & req_ready;
  assign busy      = (state == LD_LOAD);
  assign done      = (state == LD_DONE);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= LD_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Full is judged on the registered count, so the last write lands one cycle before DONE.
  always_comb begin
    next_state = state;
    case (state)
      LD_IDLE: if (start) next_state = LD_LOAD;
      LD_LOAD: begin
        if (start) begin
          next_state = LD_LOAD;
        end else if (finish || (count == DEPTH)) begin
          next_state = LD_DONE;
        end
      end
      LD_DONE: if (start) next_state = LD_LOAD;
      default: next_state = LD_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      count       <= '0;
      im_we       <= 1'b0;
      im_addr     <= '0;
      im_wdata    <= '0;
      err_illegal <= 1'b0;
    end else begin
      im_we       <= accept & ~pack_illegal;
      err_illegal <= accept & pack_illegal;
      if (start) begin
        wr_ptr <= base;
        count  <= '0;
      end else if (accept && !pack_illegal) begin
        im_addr  <= wr_ptr;
        im_wdata <= pack_word;
        wr_ptr   <= wr_ptr + PTR_ONE;  // natural wrap at 2^ADDR_W
        count    <= count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sc_instr_loader.sv
module tb_sc_instr_loader;

  localparam int AW = 6;
  localparam int DEPTH = 64;

  logic          clock;
  logic          resetn;
  logic          start;
  logic [AW-1:0] base;
  logic          finish;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_opsel, req_rs, req_rt, req_rd, req_sa;
  logic [15:0]   req_imm;
  logic [25:0]   req_target;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          busy, done, err_illegal;
  logic [AW:0]   count;

  sc_instr_loader #(.ADDR_W(AW)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .base        (base),
    .finish      (finish),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opsel   (req_opsel),
    .req_rs      (req_rs),
    .req_rt      (req_rt),
    .req_rd      (req_rd),
    .req_sa      (req_sa),
    .req_imm     (req_imm),
    .req_target  (req_target),
    .im_we       (im_we),
    .im_addr     (im_addr),
    .im_wdata    (im_wdata),
    .busy        (busy),
    .done        (done),
    .err_illegal (err_illegal),
    .count       (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Behavioural model: session state as small integers, encoding by field arithmetic.
  int          m_state = 0;  // 0 idle, 1 load, 2 done
  int          m_ptr = 0;
  int          m_cnt = 0;
  bit          m_we = 0;
  bit          m_err = 0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0] m_wdata = '0;

  int unsigned r_funct [9] = '{32, 34, 36, 37, 38, 0, 2, 3, 8};
  int unsigned i_op    [9] = '{8, 12, 13, 14, 35, 43, 4, 5, 15};
  int unsigned j_op    [2] = '{2, 3};

  function automatic logic [32:0] model_enc(input logic [4:0] sel, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [4:0] sa, input logic [15:0] imm,
                                            input logic [25:0] tgt);
    int unsigned s, a, b, c, d, w;
    logic [31:0] wv;
    s = sel; a = rs; b = rt; c = rd; d = sa;
    if (s <= 8) begin
      if (s <= 4) d = 0;
      else if (s <= 7) a = 0;
      else begin b = 0; c = 0; d = 0; end
      w = (a << 21) | (b << 16) | (c << 11) | (d << 6) | r_funct[s];
    end else if (s <= 17) begin
      if (s == 17) a = 0;
      w = (i_op[s-9] << 26) | (a << 21) | (b << 16) | imm;
    end else if (s <= 19) begin
      w = (j_op[s-18] << 26) | tgt;
    end else begin
      return {1'b0, 32'h0};
    end
    wv = w;
    return {1'b1, wv};
  endfunction

  function automatic bit m_ready();
    return (m_state == 1) && !start && !finish && (m_cnt < DEPTH);
  endfunction

  always @(posedge clock) begin : model_upd
    logic [32:0] e;
    int old_cnt;
    bit acc;
    if (!resetn) begin
      m_state = 0; m_ptr = 0; m_cnt = 0; m_we = 0; m_err = 0; m_addr = '0; m_wdata = '0;
    end else begin
      e = model_enc(req_opsel, req_rs, req_rt, req_rd, req_sa, req_imm, req_target);
      acc = req_valid && m_ready();
      old_cnt = m_cnt;
      m_we  = acc && e[32];
      m_err = acc && !e[32];
      if (m_we) begin
        m_addr  = m_ptr[AW-1:0];
        m_wdata = e[31:0];
        m_ptr   = (m_ptr + 1) % DEPTH;
        m_cnt   = m_cnt + 1;
      end
      if (start) begin
        m_state = 1; m_ptr = base; m_cnt = 0;
      end else if (m_state == 1 && (finish || old_cnt == DEPTH)) begin
        m_state = 2;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp();
    check("cyc_busy", 64'(busy), 64'(m_state == 1));
    check("cyc_done", 64'(done), 64'(m_state == 2));
    check("cyc_count", 64'(count), 64'(m_cnt));
    check("cyc_we", 64'(im_we), 64'(m_we));
    check("cyc_err", 64'(err_illegal), 64'(m_err));
    check("cyc_ready", 64'(req_ready), 64'(m_ready()));
    if (m_we) begin
      check("cyc_addr", 64'(im_addr), 64'(m_addr));
      check("cyc_wdata", 64'(im_wdata), 64'(m_wdata));
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (chk_en) cmp();
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input logic [4:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                        input logic [25:0] tgt);
    req_valid = 1'b1; req_opsel = sel; req_rs = rs; req_rt = rt; req_rd = rd;
    req_sa = sa; req_imm = imm; req_target = tgt;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic lit_write(input string nm, input int addr, input logic [31:0] word);
    check({nm, "_we"}, 64'(im_we), 64'd1);
    check({nm, "_addr"}, 64'(im_addr), 64'(addr));
    check({nm, "_wdata"}, 64'(im_wdata), 64'(word));
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; base = '0; finish = 1'b0; req_valid = 1'b0;
    req_opsel = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_sa = '0;
    req_imm = '0; req_target = '0;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_we", 64'(im_we), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    resetn = 1'b1;
    chk_en = 1;

    // Session at base 0 with the hand-encoded words.
    start = 1'b1; base = 6'd0; tick(); start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    do_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    lit_write("add", 0, 32'h00221820);
    do_req(5'd5, 5'd7, 5'd1, 5'd2, 5'd4, 16'd0, 26'd0);
    lit_write("sll", 1, 32'h00011100);
    do_req(5'd9, 5'd0, 5'd1, 5'd0, 5'd0, 16'd5, 26'd0);
    lit_write("addi", 2, 32'h20010005);
    do_req(5'd13, 5'd1, 5'd2, 5'd0, 5'd0, 16'd4, 26'd0);
    lit_write("lw", 3, 32'h8C220004);
    do_req(5'd18, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h40);
    lit_write("j", 4, 32'h08000040);
    do_req(5'd8, 5'd31, 5'd3, 5'd4, 5'd5, 16'd0, 26'd0);
    lit_write("jr", 5, 32'h03E00008);
    do_req(5'd17, 5'd3, 5'd4, 5'd0, 5'd0, 16'h1234, 26'd0);
    lit_write("lui", 6, 32'h3C041234);
    do_req(5'd1, 5'd4, 5'd5, 5'd6, 5'd9, 16'hFFFF, 26'd0);
    do_req(5'd7, 5'd9, 5'd10, 5'd11, 5'd31, 16'd0, 26'd0);
    do_req(5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3FFFFFF);
    lit_write("jal", 9, 32'h0FFFFFFF);

    // Illegal opsel: no write, pulse, pointer untouched.
    do_req(5'd25, 5'd1, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0);
    check("ill_we", 64'(im_we), 64'd0);
    check("ill_err", 64'(err_illegal), 64'd1);
    tick();
    check("ill_err_pulse", 64'(err_illegal), 64'd0);
    check("ill_count", 64'(count), 64'd10);
    do_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    lit_write("after_ill", 10, 32'h00221820);

    finish = 1'b1; tick(); finish = 1'b0;
    check("fin_done", 64'(done), 64'd1);
    check("fin_busy", 64'(busy), 64'd0);

    // Restart coincident with a request.
    start = 1'b1; base = 6'd10; tick(); start = 1'b0;
    do_req(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    start = 1'b1; base = 6'd20;
    do_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    start = 1'b0;
    check("rs_we", 64'(im_we), 64'd0);
    check("rs_count", 64'(count), 64'd0);
    do_req(5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    lit_write("rs_xor", 20, 32'h00221826);

    // Fill from base 62: wraps to 0 and stops at 64 words.
    start = 1'b1; base = 6'd62; tick(); start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      req_valid = 1'b1;
      req_opsel = 5'($urandom_range(0, 19));
      req_rs = 5'($urandom); req_rt = 5'($urandom); req_rd = 5'($urandom);
      req_sa = 5'($urandom); req_imm = 16'($urandom); req_target = 26'($urandom);
      tick();
      check("wrap_we", 64'(im_we), 64'd1);
      check("wrap_addr", 64'(im_addr), 64'((62 + i) % DEPTH));
    end
    check("full_count", 64'(count), 64'd64);
    check("full_ready", 64'(req_ready), 64'd0);
    tick();
    req_valid = 1'b0;
    check("full_done", 64'(done), 64'd1);
    check("full_we", 64'(im_we), 64'd0);

    // Reset mid-session discards the write accepted alongside it.
    start = 1'b1; base = 6'd5; tick(); start = 1'b0;
    do_req(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    resetn = 1'b0;
    do_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    check("mrst_we", 64'(im_we), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_ready", 64'(req_ready), 64'd0);
    check("mrst_addr", 64'(im_addr), 64'd0);
    check("mrst_wdata", 64'(im_wdata), 64'd0);
    check("mrst_err", 64'(err_illegal), 64'd0);
    resetn = 1'b1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
